jk_updown_counter: RTL and testbench

//  Synchronous modulo-N up/down counter whose state bits are held in a bank of jkff cells.

---
 rtl/jk_updown_counter_pkg.sv | 16 +
 rtl/jk_excite.sv | 33 +++
 rtl/jkff.sv | 34 +++
 rtl/jk_updown_counter.sv | 101 ++++++++++
 tb/tb_jk_updown_counter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK-flip-flop up/down counter: excitation codes
// and the default counter geometry.
package jk_updown_counter_pkg;

    // {J,K} pair driven into one jkff cell
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_exc_e;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 10;

endpackage

// File: rtl/jk_excite.sv
// Per-bit J/K excitation: encodes the reset > load > count > hold priority
// for one state cell.
module jk_excite
    import jk_updown_counter_pkg::*;
(
    input  logic reset,
    input  logic load,
    input  logic v_bit,
    input  logic tgl_bit,
    output logic j,
    output logic k
);

    jk_exc_e exc_s;

    // Select the excitation code for this cell
    always_comb begin
        exc_s = JK_HOLD;
        if (reset) begin
            exc_s = JK_CLR;
        end else if (load) begin
            exc_s = v_bit ? JK_SET : JK_CLR;
        end else if (tgl_bit) begin
            exc_s = JK_TGL;
        end else begin
            exc_s = JK_HOLD;
        end
    end

    assign j = exc_s[1];
    assign k = exc_s[0];

endmodule

// File: rtl/jkff.sv
// Single JK flip-flop state cell; it has no reset of its own, clearing is
// done through the J=0,K=1 excitation.
module jkff
    import jk_updown_counter_pkg::*;
(
    input  logic clock,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_d;
    logic q_q;

    // Characteristic equation of the JK cell
    always_comb begin
        q_d = q_q;
        case ({j, k})
            JK_HOLD: q_d = q_q;
            JK_CLR:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // State storage
    always_ff @(posedge clock) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-N up/down counter whose state lives in a bank of jkff cells; this
// level computes next state, per-bit excitation, terminal count and wrap.
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] tgl_s;
    logic [WIDTH-1:0] v_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic             tc_s;
    logic             wrap_d;
    logic             wrap_q;

    // Next count; >= on the up path also pulls an upset state back to zero
    always_comb begin
        next_s = q_s;
        if (up) begin
            next_s = (q_s >= MAX_VAL) ? ZERO_VAL : q_s + ONE_VAL;
        end else begin
            next_s = (q_s == ZERO_VAL) ? MAX_VAL : q_s - ONE_VAL;
        end
    end

    // Toggle mask, terminal count and saturated load value
    always_comb begin
        tgl_s = '0;
        if (en) begin
            tgl_s = q_s ^ next_s;
        end else begin
            tgl_s = '0;
        end
        v_s  = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        tc_s = en & ((up & (q_s == MAX_VAL)) | (~up & (q_s == ZERO_VAL)));
    end

    // Wrap pulse is raised only by a counting edge that passes terminal count
    always_comb begin
        wrap_d = 1'b0;
        if (reset) begin
            wrap_d = 1'b0;
        end else if (load) begin
            wrap_d = 1'b0;
        end else if (en) begin
            wrap_d = tc_s;
        end else begin
            wrap_d = 1'b0;
        end
    end

    // Wrap flop with its own reset term
    always_ff @(posedge clock) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite u_excite (
            .reset   (reset),
            .load    (load),
            .v_bit   (v_s[i]),
            .tgl_bit (tgl_s[i]),
            .j       (j_s[i]),
            .k       (k_s[i])
        );

        jkff u_jkff (
            .clock (clock),
            .j     (j_s[i]),
            .k     (k_s[i]),
            .q     (q_s[i])
        );
    end

    assign count = q_s;
    assign tc    = tc_s;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed scoreboard bench for jk_updown_counter: a MODULUS=10 instance and
// a MODULUS=16 instance share the stimulus, each step names which one is checked.
module tb_jk_updown_counter;

    logic       clock;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count10;
    logic       tc10;
    logic       wrap10;
    logic [3:0] count16;
    logic       tc16;
    logic       wrap16;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];

    jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count10),
        .tc       (tc10),
        .wrap     (wrap10)
    );

    jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count16),
        .tc       (tc16),
        .wrap     (wrap16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs; tc is checked before the edge, count/wrap after it
    task automatic step(input string tag, input bit sel16,
                        input bit r, input bit l, input logic [3:0] lv,
                        input bit e, input bit u,
                        input bit chk_tc, input bit exp_tc,
                        input logic [3:0] exp_cnt, input bit exp_wrap);
        logic [4:0] item;
        logic       obs_tc;
        logic [3:0] obs_cnt;
        logic       obs_wrap;
        reset    = r;
        load     = l;
        load_val = lv;
        en       = e;
        up       = u;
        #1;
        if (chk_tc) begin
            obs_tc = sel16 ? tc16 : tc10;
            total++;
            assert (obs_tc === exp_tc) else begin
                bad++;
                $error("FAIL %s tc: got %b expected %b", tag, obs_tc, exp_tc);
            end
        end
        exp_q.push_back({exp_wrap, exp_cnt});
        @(posedge clock);
        #1;
        item     = exp_q.pop_front();
        obs_cnt  = sel16 ? count16 : count10;
        obs_wrap = sel16 ? wrap16 : wrap10;
        total++;
        assert (obs_cnt === item[3:0]) else begin
            bad++;
            $error("FAIL %s count: got %0d expected %0d", tag, obs_cnt, item[3:0]);
        end
        total++;
        assert (obs_wrap === item[4]) else begin
            bad++;
            $error("FAIL %s wrap: got %b expected %b", tag, obs_wrap, item[4]);
        end
    endtask

    initial begin
        reset    = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        en       = 1'b0;
        up       = 1'b0;
        @(negedge clock);

        // Power-up reset
        step("reset", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step("idle_after_reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // Count up through the wrap: 1..9 then 0
        for (int i = 0; i < 10; i++) begin
            step("up10", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1,
                 1'b1, (i == 9), 4'((i + 1) % 10), (i == 9));
        end

        // Count down from 0: wraps to 9, then plain decrements
        step("down_wrap", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1);
        step("down_8", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0);
        step("down_7", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0);
        step("down_6", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0);

        // Load beats count enable
        step("load6_en", 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0);
        step("after_load6", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0);

        // Saturating load, exact MAX load, zero load then hold
        step("load13_sat", 1'b0, 1'b0, 1'b1, 4'd13, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0);
        step("load15_sat", 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
        step("load0", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("hold", 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        end

        // Reset together with load at count 5
        step("load5", 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
        step("reset_and_load", 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // Reset at terminal count suppresses the wrap pulse
        step("load9", 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0);
        step("reset_at_tc", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);

        // Load at terminal count also suppresses the wrap pulse
        step("load9_again", 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0);
        step("load_at_tc", 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
        step("hold_down_tc", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);

        // MODULUS=16 instance: full up wrap 15 -> 0, then down wrap 0 -> 15
        step("reset16", 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step("up16", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1,
                 1'b1, (i == 15), 4'((i + 1) % 16), (i == 15));
        end
        step("down16_wrap", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 1'b1);
        step("down16_14", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd14, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
